// File: rtl/imem_arbiter.sv
// Two-port round-robin read arbiter in front of a single synchronous instruction ROM.
// Grants at most one requester per cycle; the response returns one cycle later on the owner's port.
module imem_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int INIT_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Counter only needs to reach INIT_WAIT-1; keep at least one bit for INIT_WAIT <= 1.
  localparam int              CNT_W    = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (INIT_WAIT > 0) ? CNT_W'(INIT_WAIT - 1) : '0;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_prio;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rsp_vld_p1;
  logic              r_rsp_own_p1;

  logic              w_run;
  logic              w_gnt0_p0;
  logic              w_gnt1_p0;
  logic              w_gnt_p0;
  logic [ADDR_W-1:0] w_addr_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_LAST)
        r_state <= ST_RUN;
    end
  end

  assign w_run = (r_state == ST_RUN);

  // Stage p0: arbitration and ROM address (combinational grant)
  always_comb begin
    w_gnt0_p0 = 1'b0;
    w_gnt1_p0 = 1'b0;
    if (w_run) begin
      if (req0_valid && req1_valid) begin
        w_gnt0_p0 = ~r_prio;
        w_gnt1_p0 = r_prio;
      end else begin
        w_gnt0_p0 = req0_valid;
        w_gnt1_p0 = req1_valid;
      end
    end
  end

  assign w_gnt_p0  = w_gnt0_p0 | w_gnt1_p0;
  assign w_addr_p0 = w_gnt0_p0 ? req0_addr :
                     w_gnt1_p0 ? req1_addr : r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= 1'b0;
      r_addr <= '0;
    end else if (w_gnt_p0) begin
      // Priority always moves to the requester that was not just served.
      r_prio <= w_gnt0_p0;
      r_addr <= w_addr_p0;
    end
  end

  // Stage p1: ROM output returns; route it to the owner captured at grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_vld_p1 <= 1'b0;
      r_rsp_own_p1 <= 1'b0;
    end else begin
      r_rsp_vld_p1 <= w_gnt_p0;
      if (w_gnt_p0)
        r_rsp_own_p1 <= w_gnt1_p0;
    end
  end

  assign req0_ready = w_gnt0_p0;
  assign req1_ready = w_gnt1_p0;
  assign mem_addr   = w_addr_p0;
  assign init_done  = w_run;
  assign rsp0_valid = r_rsp_vld_p1 & ~r_rsp_own_p1;
  assign rsp1_valid = r_rsp_vld_p1 & r_rsp_own_p1;
  assign rsp0_data  = mem_dout;
  assign rsp1_data  = mem_dout;

endmodule
